// File: rtl/fetch_stage_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_pkg
//  Purpose  : Shared constants and the instruction-buffer entry type.
//  Revision : 1.0 - initial release
// ============================================================================
package fetch_stage_pkg;

    localparam logic [31:0] INST_NOP     = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fetch_fifo
//  Purpose  : Synchronous FIFO of fetch entries; flush wins over push.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  fetch_entry_t             entry_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output fetch_entry_t             entry_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int              PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C = (PTR_W + 1)'(DEPTH);

    fetch_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]     count_q,  count_d;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign entry_o = mem_q[rd_ptr_q];

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + (PTR_W + 1)'(1);
                2'b01:   count_d = count_q - (PTR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Sequential instruction fetch with credit-limited requests,
//             response buffering and redirect-driven flush/drop.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_VECTOR,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    output logic         imem_req_o,
    output logic [31:0]  imem_addr_o,
    input  logic         imem_gnt_i,
    input  logic         imem_rvalid_i,
    input  logic [31:0]  imem_rdata_i,
    input  logic         redirect_i,
    input  logic [31:0]  redirect_pc_i,
    output logic         instr_valid_o,
    input  logic         instr_ready_i,
    output logic [31:0]  instr_o,
    output logic [31:0]  pc_o
);

    localparam int              CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W:0]  CREDITS = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [31:0]        resp_pc_q,  resp_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_push;
    logic               fifo_pop;
    fetch_entry_t       fifo_wdata;
    fetch_entry_t       fifo_head;

    logic [CNT_W:0]     in_use;
    logic               req_fire;
    logic [31:0]        redirect_target;
    logic [CNT_W-1:0]   rvalid_ext;

    // Every issued request already owns a FIFO slot, so responses never stall.
    assign in_use          = {1'b0, outstanding_q} + {1'b0, fifo_count};
    assign imem_req_o      = !rst_i && !redirect_i && (in_use < CREDITS);
    assign imem_addr_o     = rst_i ? RESET_PC : fetch_pc_q;
    assign req_fire        = imem_req_o && imem_gnt_i;
    assign redirect_target = word_align(redirect_pc_i);
    assign rvalid_ext      = {{(CNT_W-1){1'b0}}, imem_rvalid_i};

    assign fifo_push  = imem_rvalid_i && !rst_i && !redirect_i && (drop_q == '0);
    assign fifo_wdata = '{pc: resp_pc_q, instr: imem_rdata_i};

    assign instr_valid_o = !rst_i && !redirect_i && !fifo_empty;
    assign fifo_pop      = instr_valid_o && instr_ready_i;
    assign instr_o       = (rst_i || fifo_empty) ? INST_NOP : fifo_head.instr;
    assign pc_o          = (rst_i || fifo_empty) ? 32'h0     : fifo_head.pc;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;

        case ({req_fire, imem_rvalid_i})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect_i) begin
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            // Whatever is still in flight after this cycle belongs to the old path.
            drop_d     = outstanding_q - rvalid_ext;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (imem_rvalid_i) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CNT_W'(1);
                end else begin
                    resp_pc_d = resp_pc_q + 32'd4;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .entry_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .flush_i (redirect_i),
        .entry_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
        imem_rvalid_i |-> (outstanding_q != '0));

    a_drop_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
        drop_q <= outstanding_q);

    a_credit_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
        in_use <= CREDITS);

    a_push_fits: assert property (@(posedge clk_i) disable iff (rst_i)
        fifo_push |-> (!fifo_full || fifo_pop));

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed scoreboard bench for fetch_stage with an in-order
//             memory responder of programmable latency and grant stalls.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] C_NOP      = 32'h0000_0013;
    localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

    typedef struct { logic [31:0] addr; int due; } mreq_t;
    typedef struct { logic [31:0] addr; int cyc; } glog_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] pc_o;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    logic [31:0] sb[$];
    mreq_t       pend[$];
    glog_t       gnt_log[$];
    int          lat          = 1;
    int          stall_cnt    = 0;
    bit          stall_active = 0;
    logic [31:0] stall_addr   = 32'h0;

    fetch_stage #(
        .RESET_PC   (C_RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .pc_o          (pc_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
    endtask

    task automatic do_redirect(input logic [31:0] pc, output int rcyc);
        redirect_i    = 1'b1;
        redirect_pc_i = pc;
        rcyc          = cyc;
        tick();
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
    endtask

    task automatic drain();
        bit done = 0;
        instr_ready_i = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) begin
                done = 1;
                break;
            end
            tick();
        end
        instr_ready_i = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d entries outstanding, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic wait_first_valid(output int vcyc);
        vcyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (instr_valid_o) begin
                vcyc = cyc;
                break;
            end
        end
        tick();
    endtask

    task automatic wait_grants(input int n);
        for (int i = 0; i < 20; i++) begin
            if (gnt_log.size() >= n) break;
            tick();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'h0, imem_req_o},    32'h0);
        check({tag, "_valid"}, {31'h0, instr_valid_o}, 32'h0);
        check({tag, "_instr"}, instr_o,                C_NOP);
        check({tag, "_pc"},    pc_o,                   32'h0);
        check({tag, "_addr"},  imem_addr_o,            C_RESET_PC);
    endtask

    // Instruction memory: in-order responses, data = ~address.
    initial begin
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = 32'h0;
        forever begin
            @(posedge clk_i);
            #2;
            if (rst_i) begin
                pend.delete();
                stall_active  = 0;
                imem_gnt_i    = 1'b0;
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = 32'h0;
            end else begin
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    imem_rvalid_i = 1'b1;
                    imem_rdata_i  = ~pend[0].addr;
                    void'(pend.pop_front());
                end else begin
                    imem_rvalid_i = 1'b0;
                    imem_rdata_i  = 32'h0;
                end
                if (stall_cnt > 0 && (stall_active || (imem_req_o && imem_addr_o == stall_addr))) begin
                    stall_active = 1;
                    imem_gnt_i   = 1'b0;
                    check("stall_req_held",  {31'h0, imem_req_o}, 32'h1);
                    check("stall_addr_held", imem_addr_o,         stall_addr);
                    stall_cnt--;
                    if (stall_cnt == 0) stall_active = 0;
                end else begin
                    imem_gnt_i = 1'b1;
                end
            end
            @(negedge clk_i);
            if (imem_req_o && imem_gnt_i) begin
                pend.push_back('{addr: imem_addr_o, due: cyc + lat});
                gnt_log.push_back('{addr: imem_addr_o, cyc: cyc});
            end
        end
    end

    // Monitor: every accepted instruction is compared with the scoreboard head.
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk_i);
            if (instr_valid_o && instr_ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_instr: got pc %h, required no handshake", pc_o);
                end else begin
                    exp_pc = sb.pop_front();
                    check("instr_pc",   pc_o,    exp_pc);
                    check("instr_word", instr_o, ~exp_pc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int v;
        rst_i         = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b0;

        // Reset state and sequential streaming from RESET_PC.
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_i = 1'b0;
        expect_seq(32'h0, 8);
        instr_ready_i = 1'b1;
        wait_first_valid(v);
        check("first_gnt_addr", gnt_log[0].addr, C_RESET_PC);
        check("gnt_to_valid",   32'(v),          32'(gnt_log[0].cyc + 2));
        drain();

        // Decode stalled: only two requests, then release with no loss.
        gnt_log.delete();
        do_redirect(32'h40, r);
        wait_first_valid(v);
        check("redirect_to_valid", 32'(v), 32'(r + 3));
        repeat (6) tick();
        check("stalled_gnt_count", 32'(gnt_log.size()), 32'd2);
        check("stalled_req_low",   {31'h0, imem_req_o},    32'h0);
        check("stalled_valid",     {31'h0, instr_valid_o}, 32'h1);
        check("stalled_head_pc",   pc_o,                   32'h40);
        expect_seq(32'h40, 4);
        drain();

        // Grant withheld for three cycles on address 0x8.
        gnt_log.delete();
        expect_seq(32'h0, 6);
        stall_addr = 32'h8;
        stall_cnt  = 3;
        do_redirect(32'h0, r);
        drain();
        check("stall_consumed", 32'(stall_cnt),  32'd0);
        check("gnt_after_4",    gnt_log[2].addr, 32'h8);
        check("gnt_after_8",    gnt_log[3].addr, 32'hC);

        // Redirect with two requests in flight: both responses dropped.
        lat = 3;
        gnt_log.delete();
        do_redirect(32'h400, r);
        wait_grants(2);
        check("inflight_before_redirect", 32'(gnt_log.size()), 32'd2);
        lat = 1;
        gnt_log.delete();
        expect_seq(32'h100, 4);
        do_redirect(32'h100, r);
        drain();
        check("redirect_100_addr", gnt_log[0].addr, 32'h100);

        // Redirect coinciding with a response; misaligned target.
        lat = 2;
        gnt_log.delete();
        do_redirect(32'h300, r);
        wait_grants(2);
        lat = 1;
        gnt_log.delete();
        expect_seq(32'h200, 3);
        do_redirect(32'h203, r);
        drain();
        check("redirect_203_addr", gnt_log[0].addr, 32'h200);

        // Address wrap, then reset in the middle of the stream.
        gnt_log.delete();
        expect_seq(32'hFFFF_FFF8, 4);
        do_redirect(32'hFFFF_FFF8, r);
        drain();
        check("wrap_gnt_fffc", gnt_log[1].addr, 32'hFFFF_FFFC);
        check("wrap_gnt_0",    gnt_log[2].addr, 32'h0);
        rst_i = 1'b1;
        #1;
        check_reset_outputs("midreset");
        tick();
        check_reset_outputs("midreset_held");
        gnt_log.delete();
        rst_i = 1'b0;
        expect_seq(C_RESET_PC, 4);
        drain();
        check("restart_addr", gnt_log[0].addr, C_RESET_PC);

        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
